// File: rtl/vfd_freq_meas.sv
// vfd_freq_meas: square-wave frequency meter, reports CLK_HZ / period in Hz, 0 Hz on stall
module vfd_freq_meas #(
    parameter logic [31:0] CLK_HZ  = 32'd50_000_000,
    parameter logic [31:0] TIMEOUT = 32'd50_000_000
) (
    input  logic       clk_sys,
    input  logic       rst_n,
    input  logic       sig_in,
    output logic [9:0] freq,
    output logic       freq_vld,
    output logic       meas_ok
);
    localparam logic [1:0] S_WAIT = 2'd0;
    localparam logic [1:0] S_CNT  = 2'd1;
    localparam logic [1:0] S_DIV  = 2'd2;
    localparam logic [1:0] S_OUT  = 2'd3;
    logic        r_s1, r_s2, r_s3;
    logic [31:0] r_cnt, r_div, r_rem, r_quo;
    logic [4:0]  r_bit;
    logic [1:0]  r_state;
    logic [9:0]  r_freq;
    logic        r_vld, r_ok;
    logic        w_rise, w_to, w_ge;
    logic [32:0] w_trial, w_sub;
    assign w_rise   = r_s2 & ~r_s3;
    assign w_to     = (r_cnt == TIMEOUT);
    assign w_trial  = {r_rem, r_quo[31]};
    assign w_sub    = w_trial - {1'b0, r_div};
    assign w_ge     = ~w_sub[32];
    assign freq     = r_freq;
    assign freq_vld = r_vld;
    assign meas_ok  = r_ok;
    // synchronize the asynchronous input and keep one extra stage for edge detection
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_s3 <= 1'b0;
        end else begin
            r_s1 <= sig_in;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end
    // free-running period counter, restarted by every rise and saturating at TIMEOUT
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n)
            r_cnt <= 32'd0;
        else
            r_cnt <= w_rise ? 32'd1 : (w_to ? r_cnt : r_cnt + 32'd1);
    end
    // measurement FSM: latch period, restoring divide one bit per cycle, publish saturated result
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_WAIT;
            r_div   <= 32'd0;
            r_rem   <= 32'd0;
            r_quo   <= 32'd0;
            r_bit   <= 5'd0;
            r_freq  <= 10'd0;
            r_vld   <= 1'b0;
            r_ok    <= 1'b0;
        end else begin
            r_vld <= 1'b0;
            case (r_state)
                S_WAIT: r_state <= w_rise ? S_CNT : S_WAIT;
                S_CNT: begin
                    if (w_rise) begin
                        r_div   <= r_cnt;
                        r_rem   <= 32'd0;
                        r_quo   <= CLK_HZ;
                        r_bit   <= 5'd0;
                        r_state <= S_DIV;
                    end else if (w_to) begin
                        r_freq  <= 10'd0;
                        r_ok    <= 1'b0;
                        r_vld   <= 1'b1;
                        r_state <= S_WAIT;
                    end
                end
                S_DIV: begin
                    r_rem   <= w_ge ? w_sub[31:0] : w_trial[31:0];
                    r_quo   <= {r_quo[30:0], w_ge};
                    r_bit   <= r_bit + 5'd1;
                    r_state <= (r_bit == 5'd31) ? S_OUT : S_DIV;
                end
                default: begin
                    r_freq  <= (|r_quo[31:10]) ? 10'd1023 : r_quo[9:0];
                    r_ok    <= 1'b1;
                    r_vld   <= 1'b1;
                    r_state <= S_CNT;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_vfd_freq_meas.sv
// tb_vfd_freq_meas: directed scenarios for the frequency meter with a scaled-down clock rate
module tb_vfd_freq_meas;
    localparam logic [31:0] CLK_HZ  = 32'd50_000;
    localparam logic [31:0] TIMEOUT = 32'd3000;
    logic       clk_sys = 1'b0;
    logic       rst_n;
    logic       sig_in;
    logic [9:0] freq;
    logic       freq_vld;
    logic       meas_ok;
    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int dbl = 0;
    logic prev_v = 1'b0;
    int pf[$];
    int po[$];
    int pt[$];
    int t, t1;
    vfd_freq_meas #(.CLK_HZ(CLK_HZ), .TIMEOUT(TIMEOUT)) dut (
        .clk_sys (clk_sys),
        .rst_n   (rst_n),
        .sig_in  (sig_in),
        .freq    (freq),
        .freq_vld(freq_vld),
        .meas_ok (meas_ok)
    );
    always #5 clk_sys = ~clk_sys;
    always @(posedge clk_sys) cyc <= cyc + 1;
    // record every output pulse with its value and cycle stamp
    always @(negedge clk_sys) begin
        if (freq_vld) begin
            pf.push_back(int'(freq));
            po.push_back(int'(meas_ok));
            pt.push_back(cyc);
        end
        if (freq_vld && prev_v) dbl++;
        prev_v = freq_vld;
    end
    function automatic int qf(input int i);
        return (i < pf.size()) ? pf[i] : -1;
    endfunction
    function automatic int qo(input int i);
        return (i < po.size()) ? po[i] : -1;
    endfunction
    function automatic int qt(input int i);
        return (i < pt.size()) ? pt[i] : -1;
    endfunction
    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask
    task automatic clearq();
        pf.delete();
        po.delete();
        pt.delete();
    endtask
    // rising edge on sig_in now, next rise allowed exactly gap cycles later
    task automatic rise_then(input int gap, output int tr);
        @(negedge clk_sys);
        sig_in = 1'b1;
        tr = cyc;
        repeat (gap / 2) @(negedge clk_sys);
        sig_in = 1'b0;
        repeat (gap - gap / 2 - 1) @(negedge clk_sys);
    endtask
    task automatic do_reset();
        @(negedge clk_sys);
        rst_n = 1'b0;
        repeat (3) @(negedge clk_sys);
        rst_n = 1'b1;
        clearq();
    endtask
    initial begin
        rst_n = 1'b0;
        sig_in = 1'b0;
        repeat (3) @(negedge clk_sys);
        chk("reset_freq", int'(freq), 0);
        chk("reset_vld", int'(freq_vld), 0);
        chk("reset_ok", int'(meas_ok), 0);
        rst_n = 1'b1;
        clearq();
        // 50 Hz equivalent: period 1000 cycles
        rise_then(1000, t);
        rise_then(1000, t1);
        rise_then(1000, t);
        rise_then(100, t);
        chk("s1_count", pf.size(), 3);
        chk("s1_f0", qf(0), 50);
        chk("s1_ok0", qo(0), 1);
        chk("s1_f2", qf(2), 50);
        chk("s1_latency", qt(0) - t1, 36);
        chk("s1_spacing", qt(1) - qt(0), 1000);
        chk("s1_hold", int'(freq), 50);
        // period 50 then period 1001 (truncation)
        do_reset();
        rise_then(50, t);
        rise_then(50, t);
        rise_then(50, t);
        rise_then(1001, t);
        rise_then(1001, t);
        rise_then(100, t);
        chk("s2_count", pf.size(), 5);
        chk("s2_f0", qf(0), 1000);
        chk("s2_f2", qf(2), 1000);
        chk("s2_f3", qf(3), 49);
        chk("s2_f4", qf(4), 49);
        // period 20: saturation, every other rise lands in the divide
        do_reset();
        rise_then(20, t);
        rise_then(20, t);
        rise_then(20, t);
        rise_then(20, t);
        rise_then(100, t);
        chk("s3_count", pf.size(), 2);
        chk("s3_f0", qf(0), 1023);
        chk("s3_f1", qf(1), 1023);
        chk("s3_ok1", qo(1), 1);
        // stall -> single 0 Hz pulse TIMEOUT after the last rise
        do_reset();
        rise_then(50, t);
        rise_then(50, t);
        rise_then(6000, t1);
        chk("s4_count", pf.size(), 3);
        chk("s4_last_meas", qf(1), 1000);
        chk("s4_to_f", qf(2), 0);
        chk("s4_to_ok", qo(2), 0);
        chk("s4_to_time", qt(2) - t1, int'(TIMEOUT) + 3);
        chk("s4_freq", int'(freq), 0);
        chk("s4_ok", int'(meas_ok), 0);
        rise_then(1000, t);
        chk("s4_first_rise_silent", pf.size(), 3);
        rise_then(100, t);
        chk("s4_restart_count", pf.size(), 4);
        chk("s4_restart_f", qf(3), 50);
        chk("s4_restart_ok", qo(3), 1);
        // a rise during the divide is dropped but restarts the period
        do_reset();
        rise_then(1000, t);
        rise_then(10, t);
        rise_then(50, t);
        rise_then(50, t);
        rise_then(100, t);
        chk("s5_count", pf.size(), 3);
        chk("s5_f0", qf(0), 50);
        chk("s5_f1", qf(1), 1000);
        chk("s5_f2", qf(2), 1000);
        // asynchronous reset in the middle of a division
        do_reset();
        rise_then(1000, t);
        rise_then(1000, t);
        rise_then(15, t);
        chk("s6_pre_count", pf.size(), 1);
        chk("s6_pre_f", int'(freq), 50);
        #2;
        rst_n = 1'b0;
        #1;
        chk("s6_async_freq", int'(freq), 0);
        chk("s6_async_ok", int'(meas_ok), 0);
        chk("s6_async_vld", int'(freq_vld), 0);
        clearq();
        repeat (3) @(negedge clk_sys);
        rst_n = 1'b1;
        repeat (100) @(negedge clk_sys);
        chk("s6_no_pulse", pf.size(), 0);
        rise_then(1000, t);
        rise_then(100, t1);
        chk("s6_count", pf.size(), 1);
        chk("s6_f", qf(0), 50);
        chk("s6_ok", qo(0), 1);
        chk("s6_latency", qt(0) - t1, 36);
        chk("no_double_vld", dbl, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
